// File: rtl/rotor_stage.sv
// rotor_stage: loadable Enigma rotor permutation with inverse build, stepping position, programmable latency and turnover carry
module rotor_stage #(
  parameter int N = 26,
  parameter int W = 8,
  parameter int DELAY_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic             valid,
  input  logic             rot,
  input  logic [W-1:0]     din,
  input  logic [W-1:0]     offset,
  input  logic [W-1:0]     notch,
  input  logic [DELAY_W-1:0] delay,
  input  logic [N*W-1:0]   idx_in,
  input  logic             dec,
  output logic [W-1:0]     dout,
  output logic             done,
  output logic             carry,
  output logic             ready,
  output logic             config_err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] UNCONF = 3'd0, BUILD = 3'd1, READY = 3'd2, BUSY = 3'd3, ERR = 3'd4;
  localparam logic [W:0] NN = (W+1)'(N);
  logic [2:0] state;
  logic [W-1:0] fwd [N];
  logic [W-1:0] inv [N];
  logic [N-1:0] written;
  logic [W-1:0] pos, notch_q, res;
  logic [DELAY_W-1:0] dly, cnt;
  logic [IW-1:0] bi;
  logic bad_seen;
  logic [W:0] sum, diff;
  logic [IW-1:0] ei, fi;
  logic [W-1:0] f, m, enc;
  logic bad, flagged, accept, step;
  always_comb begin
    sum = {1'b0, din} + {1'b0, pos};
    ei = IW'(sum >= NN ? sum - NN : sum);
    m = dec ? inv[ei] : fwd[ei];
    diff = {1'b0, m} + NN - {1'b0, pos};
    enc = ({1'b0, din} < NN) ? W'(diff >= NN ? diff - NN : diff) : din;
    f = fwd[bi];
    fi = IW'(f);
    bad = ({1'b0, f} >= NN) || written[fi];
    flagged = bad_seen || bad;
    accept = (state == READY) && en && valid;
    step = en && rot && ((state == READY) || (state == BUSY));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= UNCONF;
      dout <= '0;
      done <= 1'b0;
      carry <= 1'b0;
      ready <= 1'b0;
      config_err <= 1'b0;
      pos <= '0;
      notch_q <= '0;
      res <= '0;
      dly <= '0;
      cnt <= '0;
      bi <= '0;
      bad_seen <= 1'b0;
      written <= '0;
      for (int k = 0; k < N; k++) begin
        fwd[k] <= '0;
        inv[k] <= '0;
      end
    end else if (set) begin
      for (int k = 0; k < N; k++) fwd[k] <= idx_in[k*W +: W];
      written <= '0;
      pos <= W'({1'b0, offset} % NN);
      notch_q <= notch;
      dly <= delay;
      bi <= '0;
      bad_seen <= 1'b0;
      state <= BUILD;
      ready <= 1'b0;
      config_err <= 1'b0;
      done <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      carry <= step && (pos == notch_q);
      if (step) pos <= (pos == W'(N-1)) ? '0 : pos + 1'b1;
      if (state == BUILD) begin
        if (bad) bad_seen <= 1'b1;
        else begin
          inv[fi] <= W'(bi);
          written[fi] <= 1'b1;
        end
        if (bi == IW'(N-1)) begin
          state <= flagged ? ERR : READY;
          ready <= !flagged;
          config_err <= flagged;
        end else bi <= bi + 1'b1;
      end else if (accept) begin
        res <= enc;
        cnt <= '0;
        state <= BUSY;
        ready <= 1'b0;
        if (dly == '0) begin
          dout <= enc;
          done <= 1'b1;
        end
      end else if (state == BUSY) begin
        if (cnt == dly) begin
          state <= READY;
          ready <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt + 1'b1 == dly) begin
            dout <= res;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/rotor_stage.md
# rotor_stage

Parametrised Enigma rotor stage: holds one loadable wiring permutation over an N-symbol alphabet and builds its inverse internally. It substitutes symbols forward for encryption or inverse for decryption, relative to a steppable rotor position, with a programmable output latency. A turnover carry output allows stages to be chained into a multi-rotor stack with reflector and plugboard blocks.

## Interface
- N, 26, alphabet size; symbols are indices 0..N-1.
- W, 8, symbol width; W ≥ clog2(N).
- DELAY_W, 32, width of the latency field.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- set  in  1  load configuration pulse
- en  in  1  stage enable; gates valid and rot
- valid  in  1  din carries a symbol this cycle
- rot  in  1  step rotor position by one
- din  in  W  input symbol
- offset  in  W  initial rotor position, captured on set, reduced mod N
- notch  in  W  turnover position, captured on set
- delay  in  DELAY_W  extra output latency in cycles, captured on set
- idx_in  in  N*W  forward wiring; entry i at bits [i*W +: W]
- dec  in  1  1 = inverse (decrypt) path, sampled with valid
- dout  out  W  substituted symbol, held until next result
- done  out  1  one-cycle pulse, dout valid
- carry  out  1  one-cycle turnover pulse to next stage
- ready  out  1  configured and idle
- config_err  out  1  wiring is not a permutation of 0..N-1

## Operation
- States: UNCONF, BUILD, READY, BUSY, ERR. Reset → UNCONF; dout=0, done=0, carry=0, ready=0, config_err=0, pos=0, tables cleared.
- Set (any state, en ignored): capture idx_in into fwd[], offset mod N into pos, notch, delay; clear written-flag vector; go to BUILD; ready=0, config_err=0. Any in-flight BUSY symbol is dropped with no done.
- BUILD: counter i = 0..N-1, one entry per cycle. If fwd[i] ≥ N or written[fwd[i]] is already set, flag error. Otherwise write inv[fwd[i]] = i and set written[fwd[i]]. After the last entry, go to ERR if flagged (config_err=1, ready=0); otherwise go to READY (ready=1).
- ERR: held until set or reset; valid and rot ignored.
- READY, en=1, valid=1: capture din and dec, then go to BUSY with ready=0.
  - din < N: e = (din + pos) mod N; m = dec ? inv[e] : fwd[e]; result = (m − pos + N) mod N.
  - din ≥ N: result = din passthrough.
- Encoding uses the pos value of the capture cycle.
- BUSY: counter runs from 0 to delay. On reaching delay, dout ← result, done=1 for one cycle, return to READY.
- valid during BUSY, BUILD or UNCONF is dropped with no response.
- Rotation: rot=1, en=1 in READY or BUSY gives pos ← (pos+1) mod N. carry=1 on the following cycle if the old pos == notch.
  - Wrap N−1 → 0 is ordinary.
  - rot is ignored in UNCONF, BUILD and ERR.
- Simultaneous valid and rot in READY: the symbol encodes with the old pos, and the step takes effect after.
- All mod arithmetic is done at W+1 bits, so there is no overflow for N ≤ 2^W.

## Timing
- set at cycle t: BUILD occupies t+1..t+N; ready or config_err rises at t+N+1.
- valid accepted at cycle t: done at t+1+delay. For delay=0, done is at t+1.
- Back-to-back throughput is one symbol per delay+2 cycles: ready returns in the cycle after done.
- carry: registered, one cycle after the stepping rot.
- dout changes only on a done cycle or on reset.
- reset mid-operation: all outputs return to reset values on the next edge; the next set is required before use.

## Test plan
- Load wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ (N=26), offset=0, delay=0 → ready at t+27. Encode din=0 → dout=4, done at t+1. Decode din=4 with dec=1 → dout=0.
- Same wiring, offset=1: din=0 → e=1, fwd[1]=10 → dout=9. Decode din=9 → dout=0.
- notch=16, offset=16: rot pulse → pos=17, carry=1 for one cycle. A second rot gives no carry. offset=25 plus rot → pos=0, no carry.
- delay=5, valid at t → done only at t+6. A second valid at t+2 is dropped. set at t+3 aborts the symbol: no done, BUILD restarts.
- Wiring with fwd[0]=fwd[1]=0 → config_err=1 at t+27, ready=0. valid ignored. A set with valid wiring clears the error.
- valid and rot in the same READY cycle at pos=0 with identity wiring, din=3 → dout=3. The next symbol, din=3, also gives dout=3 because identity is position-invariant. Repeat with wiring I: the first result uses pos 0 and the second uses pos 1.
